// File: rtl/imm_defs_pkg.sv
// Shared width codes, select codes and field widths for the immediate narrowing path.
// The optional saturating behaviour (IMM_NARROW_SAT_EN) is applied through sat_field().
package imm_defs;

  localparam logic [1:0] W4       = 2'b00;
  localparam logic [1:0] W9       = 2'b01;
  localparam logic [1:0] W12      = 2'b10;
  localparam logic [1:0] SEL_AUTO = 2'b11;

  localparam int unsigned FW4  = 4;
  localparam int unsigned FW9  = 9;
  localparam int unsigned FW12 = 12;

  typedef enum logic [1:0] {
    SEL_W4  = 2'b00,
    SEL_W9  = 2'b01,
    SEL_W12 = 2'b10,
    SEL_AU  = 2'b11
  } sel_e;

  typedef struct packed {
    logic        fit;
    logic [11:0] field;
  } fit_res_t;

  // Saturated N-bit field: max positive for a non-negative value, most negative otherwise.
  function automatic logic [11:0] sat_field(input logic neg, input logic [1:0] wcode);
    logic [11:0] f;
    f = '0;
    case (wcode)
      W4:      f = neg ? 12'h008 : 12'h007;
      W9:      f = neg ? 12'h100 : 12'h0FF;
      default: f = neg ? 12'h800 : 12'h7FF;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/imm_fit_check.sv
// Combinational check of whether a 16-bit value sign-extends from the chosen field width,
// plus the right-aligned field. Build option: IMM_NARROW_SAT_EN saturates non-fitting fields.
module imm_fit_check
  import imm_defs::*;
(
  input  logic [15:0] i_value,
  input  logic [1:0]  i_width,
  output logic        o_fit,
  output logic [11:0] o_field
);

  logic        w_fit;
  logic [11:0] w_trunc;

  // A value fits width N when bits [15:N-1] are all copies of the sign bit.
  always_comb begin
    w_fit   = 1'b0;
    w_trunc = '0;
    case (i_width)
      W4: begin
        w_fit   = (i_value[15:3] == '0) || (i_value[15:3] == '1);
        w_trunc = {8'b0, i_value[3:0]};
      end
      W9: begin
        w_fit   = (i_value[15:8] == '0) || (i_value[15:8] == '1);
        w_trunc = {3'b0, i_value[8:0]};
      end
      W12: begin
        w_fit   = (i_value[15:11] == '0) || (i_value[15:11] == '1);
        w_trunc = i_value[11:0];
      end
      default: begin
        w_fit   = 1'b0;
        w_trunc = '0;
      end
    endcase
  end

  assign o_fit = w_fit;

`ifdef IMM_NARROW_SAT_EN
  assign o_field = w_fit ? w_trunc : sat_field(i_value[15], i_width);
`else
  assign o_field = w_trunc;
`endif

endmodule

// File: rtl/imm_narrow.sv
// Two-stage valid/ready pipeline narrowing a 16-bit value to a 4/9/12-bit immediate,
// with a saturating count of delivered non-fitting beats. Build option: IMM_NARROW_SAT_EN.
module imm_narrow
  import imm_defs::*;
#(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [15:0]          in_data,
  input  logic [1:0]           in_sel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [11:0]          out_field,
  output logic [1:0]           out_width,
  output logic                 out_fit,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  // Handshake: a beat moves across a port on any rising edge where valid && ready.
  // Producers hold valid and data until that edge; ready never depends on in_valid.

  logic                 r_s1_valid;
  logic [15:0]          r_s1_data;
  logic [1:0]           r_s1_sel;

  logic                 r_out_valid;
  logic [11:0]          r_out_field;
  logic [1:0]           r_out_width;
  logic                 r_out_fit;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  logic                 w_s2_open;
  logic                 w_s1_adv;
  logic                 w_in_xfer;
  logic                 w_out_xfer;

  fit_res_t             w_r4, w_r9, w_r12;
  logic                 w_fit;
  logic [11:0]          w_field;
  logic [1:0]           w_width;

  assign w_s2_open  = !r_out_valid || out_ready;
  assign w_s1_adv   = r_s1_valid && w_s2_open;
  assign in_ready   = !r_s1_valid || w_s1_adv;
  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = r_out_valid && out_ready;

  imm_fit_check u_fit4 (
    .i_value (r_s1_data),
    .i_width (W4),
    .o_fit   (w_r4.fit),
    .o_field (w_r4.field)
  );

  imm_fit_check u_fit9 (
    .i_value (r_s1_data),
    .i_width (W9),
    .o_fit   (w_r9.fit),
    .o_field (w_r9.field)
  );

  imm_fit_check u_fit12 (
    .i_value (r_s1_data),
    .i_width (W12),
    .o_fit   (w_r12.fit),
    .o_field (w_r12.field)
  );

  // Auto picks the narrowest fitting width; with no fit it falls back to 12 bits, fit=0.
  always_comb begin
    w_fit   = w_r12.fit;
    w_field = w_r12.field;
    w_width = W12;
    case (r_s1_sel)
      W4: begin
        w_fit   = w_r4.fit;
        w_field = w_r4.field;
        w_width = W4;
      end
      W9: begin
        w_fit   = w_r9.fit;
        w_field = w_r9.field;
        w_width = W9;
      end
      W12: begin
        w_fit   = w_r12.fit;
        w_field = w_r12.field;
        w_width = W12;
      end
      default: begin
        if (w_r4.fit) begin
          w_fit   = 1'b1;
          w_field = w_r4.field;
          w_width = W4;
        end else if (w_r9.fit) begin
          w_fit   = 1'b1;
          w_field = w_r9.field;
          w_width = W9;
        end else begin
          w_fit   = w_r12.fit;
          w_field = w_r12.field;
          w_width = W12;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_sel   <= '0;
    end else begin
      if (w_in_xfer) begin
        r_s1_valid <= 1'b1;
        r_s1_data  <= in_data;
        r_s1_sel   <= in_sel;
      end else if (w_s1_adv) begin
        r_s1_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_field <= '0;
      r_out_width <= '0;
      r_out_fit   <= 1'b0;
    end else if (w_s2_open) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_field <= w_field;
        r_out_width <= w_width;
        r_out_fit   <= w_fit;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if (w_out_xfer && !r_out_fit && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign out_valid = r_out_valid;
  assign out_field = r_out_field;
  assign out_width = r_out_width;
  assign out_fit   = r_out_fit;
  assign err_cnt   = r_err_cnt;

endmodule
